// File: rtl/sounder_rx_seq.sv
// sounder_rx_seq: sequencer for the sounder receive correlator.
// Each period of one PN code length accumulates one lag. The reference strobe
// moves back one sample per period, so successive periods see successive lags.
// The first period after start is a warm-up whose total is discarded.
// Optional feature macro SOUNDER_RX_SEQ_DWELL_EN adds dwell_i: each lag is held
// for dwell_i+1 periods. Without it every lag lasts exactly one period.
// Handshake: start_i is a one-cycle request sampled only in IDLE. resp_valid_o
// qualifies resp_lag_o for exactly one cycle, one cycle after the sum strobe
// that closed a scored period. abort_i overrides every other event.
module sounder_rx_seq #(
  parameter int SWEEP_W = 8,
  parameter int LEN_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [4:0]         degree_i,
  input  logic [SWEEP_W-1:0] nsweeps_i,
`ifdef SOUNDER_RX_SEQ_DWELL_EN
  input  logic [7:0]         dwell_i,
`endif
  output logic               ena_o,
  output logic               sum_strobe_o,
  output logic               ref_strobe_o,
  output logic               resp_valid_o,
  output logic [LEN_W-1:0]   resp_lag_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         deg_q, deg_d;
  logic [SWEEP_W-1:0] nsweeps_q, nsweeps_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic [LEN_W-1:0]   smp_q, smp_d;
  logic [LEN_W-1:0]   lag_q, lag_d;
  logic [LEN_W-1:0]   resp_lag_q, resp_lag_d;
  logic               warm_q, warm_d;
  logic               resp_valid_q, resp_valid_d;
  logic               err_q, err_d;

  logic [LEN_W-1:0]   len_w;
  logic [LEN_W-1:0]   last_smp;
  logic [SWEEP_W-1:0] sweep_inc;
  logic               deg_ok;
  logic               accept_start;
  logic               period_end;
  logic               scored_period;
  logic               lag_hold_done;

  // Code length is a mask of deg ones; deg = 16 shifts everything out -> 0xFFFF.
  assign len_w         = ~({LEN_W{1'b1}} << deg_q);
  assign last_smp      = len_w - LEN_W'(1);
  assign sweep_inc     = sweep_q + SWEEP_W'(1);
  assign deg_ok        = (degree_i >= 5'd2) && (degree_i <= 5'd16);
  assign accept_start  = (state_q == ST_IDLE) && !abort_i && start_i && deg_ok;
  assign period_end    = (state_q == ST_RUN) && !abort_i && (smp_q == last_smp);
  assign scored_period = period_end && !warm_q;

`ifdef SOUNDER_RX_SEQ_DWELL_EN
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] dwell_cnt_q, dwell_cnt_d;

  assign lag_hold_done = (dwell_cnt_q == dwell_q);

  // Dwell bookkeeping: count scored periods spent on the current lag.
  always_comb begin
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    if (accept_start) begin
      dwell_d     = dwell_i;
      dwell_cnt_d = '0;
    end else if (scored_period) begin
      dwell_cnt_d = lag_hold_done ? 8'd0 : dwell_cnt_q + 8'd1;
    end
  end

  // Dwell registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
    end else begin
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end
`else
  assign lag_hold_done = 1'b1;
`endif

  // Next-state and counter logic; abort overrides everything and drops pending responses.
  always_comb begin
    state_d      = state_q;
    deg_d        = deg_q;
    nsweeps_d    = nsweeps_q;
    sweep_d      = sweep_q;
    smp_d        = smp_q;
    lag_d        = lag_q;
    warm_d       = warm_q;
    resp_valid_d = 1'b0;
    resp_lag_d   = '0;
    err_d        = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (deg_ok) begin
              deg_d     = degree_i;
              nsweeps_d = nsweeps_i;
              smp_d     = '0;
              lag_d     = '0;
              sweep_d   = '0;
              warm_d    = 1'b1;
              state_d   = ST_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          smp_d = smp_q + LEN_W'(1);
          if (period_end) begin
            smp_d = '0;
            if (warm_q) begin
              warm_d = 1'b0;
            end else begin
              resp_valid_d = 1'b1;
              resp_lag_d   = lag_q;
              if (lag_hold_done) begin
                if (lag_q == last_smp) begin
                  lag_d   = '0;
                  sweep_d = sweep_inc;
                  if ((sweep_inc == nsweeps_q) && (nsweeps_q != '0)) begin
                    state_d = ST_DONE;
                  end
                end else begin
                  lag_d = lag_q + LEN_W'(1);
                end
              end
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      deg_q        <= '0;
      nsweeps_q    <= '0;
      sweep_q      <= '0;
      smp_q        <= '0;
      lag_q        <= '0;
      warm_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_lag_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      deg_q        <= deg_d;
      nsweeps_q    <= nsweeps_d;
      sweep_q      <= sweep_d;
      smp_q        <= smp_d;
      lag_q        <= lag_d;
      warm_q       <= warm_d;
      resp_valid_q <= resp_valid_d;
      resp_lag_q   <= resp_lag_d;
      err_q        <= err_d;
    end
  end

  assign ena_o        = (state_q == ST_RUN);
  assign sum_strobe_o = (state_q == ST_RUN) && (smp_q == last_smp);
  assign ref_strobe_o = (state_q == ST_RUN) && (smp_q == lag_q);
  assign resp_valid_o = resp_valid_q;
  assign resp_lag_o   = resp_lag_q;
  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

endmodule
